// File: rtl/ca_pkg.sv
// Shared definitions for the cellular-automaton rule scheduler: default rule
// list, frame geometry and the commit FSM state encoding.
package ca_pkg;

   localparam int ROWS_PER_FRAME = 120;
   localparam int DEFAULT_RULE_COUNT = 8;

   typedef enum logic {
      ST_RUN    = 1'b0,
      ST_COMMIT = 1'b1
   } state_t;

   // Power-on rule list; slots beyond the list repeat it.
   function automatic logic [7:0] default_rule(input int k);
      logic [7:0] r;
      case (k % DEFAULT_RULE_COUNT)
         0:       r = 8'd30;
         1:       r = 8'd110;
         2:       r = 8'd22;
         3:       r = 8'd73;
         4:       r = 8'd90;
         5:       r = 8'd146;
         6:       r = 8'd105;
         default: r = 8'd102;
      endcase
      return r;
   endfunction

endpackage

// File: rtl/ca_rule_table.sv
// Double-buffered rule storage: cfg writes land in shadow, the scheduler copies
// shadow entries into active one slot at a time, and the display reads active.
module ca_rule_table
   import ca_pkg::*;
#(
   parameter int NUM_RULES = 8
) (
   input  logic       clk,
   input  logic       rst_n,
   input  logic       wr_en,
   input  logic [2:0] wr_addr,
   input  logic [7:0] wr_data,
   input  logic       copy_en,
   input  logic [2:0] copy_addr,
   input  logic [2:0] rd_addr,
   output logic [7:0] rd_data
);

   logic [7:0] shadow [NUM_RULES];
   logic [7:0] active [NUM_RULES];

   // Both banks return to the defaults so a reset mid-copy leaves nothing half-committed.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         for (int k = 0; k < NUM_RULES; k++) begin
            shadow[k] <= default_rule(k);
            active[k] <= default_rule(k);
         end
      end else begin
         if (wr_en)
            shadow[wr_addr] <= wr_data;
         if (copy_en)
            active[copy_addr] <= shadow[copy_addr];
      end
   end

   assign rd_data = active[rd_addr];

endmodule

// File: rtl/ca_rule_scheduler.sv
// Selects the Wolfram rule for each displayed cell row from the generation
// counter, scrolls one row per frame, and commits rule edits during blanking.
module ca_rule_scheduler #(
   parameter int NUM_RULES      = 8,
   parameter int ROWS_PER_FRAME = ca_pkg::ROWS_PER_FRAME,
   parameter int GEN_W          = 11
) (
   input  logic       clk,
   input  logic       rst_n,
   input  logic       row_tick,
   input  logic       frame_tick,
   input  logic       pause,
   input  logic       seed_req,
   input  logic       cfg_valid,
   input  logic [2:0] cfg_addr,
   input  logic [7:0] cfg_data,
   output logic       cfg_ready,
   output logic [7:0] rule_o,
   output logic [5:0] color_o,
   output logic [2:0] rule_idx_o,
   output logic       seed_o,
   output logic       busy_o
);
   import ca_pkg::*;

   // Adding this per frame nets one row of upward scroll after ROWS_PER_FRAME row ticks.
   localparam logic [GEN_W-1:0] SCROLL_ADD = GEN_W'(1 - ROWS_PER_FRAME);
   localparam logic [2:0]       LAST_SLOT  = 3'(NUM_RULES - 1);

   state_t           state, state_nxt;
   logic             dirty;
   logic             go_commit;
   logic             copy_en;
   logic             accept;
   logic [2:0]       copy_idx;
   logic [GEN_W-1:0] gen_cnt;
   logic [2:0]       gen_idx;
   logic [7:0]       active_rule;

   always_comb begin
      state_nxt = state;
      cfg_ready = 1'b0;
      busy_o    = 1'b0;
      go_commit = 1'b0;
      copy_en   = 1'b0;
      case (state)
         ST_RUN: begin
            cfg_ready = 1'b1;
            if (frame_tick && (dirty || cfg_valid)) begin
               go_commit = 1'b1;
               state_nxt = ST_COMMIT;
            end
         end
         ST_COMMIT: begin
            busy_o  = 1'b1;
            copy_en = 1'b1;
            if (copy_idx == LAST_SLOT)
               state_nxt = ST_RUN;
         end
         default: state_nxt = ST_RUN;
      endcase
   end

   assign accept = cfg_valid && cfg_ready;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state    <= ST_RUN;
         dirty    <= 1'b0;
         copy_idx <= '0;
      end else begin
         state <= state_nxt;
         if (go_commit)
            dirty <= 1'b0;
         else if (accept)
            dirty <= 1'b1;
         copy_idx <= (state == ST_COMMIT) ? copy_idx + 3'd1 : 3'd0;
      end
   end

   // Frame scroll wins over a coincident row tick.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n)
         gen_cnt <= '0;
      else if (!pause) begin
         if (frame_tick)
            gen_cnt <= gen_cnt + SCROLL_ADD;
         else if (row_tick)
            gen_cnt <= gen_cnt + 1'b1;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n)
         seed_o <= 1'b1;
      else if (seed_req)
         seed_o <= 1'b1;
      else if (frame_tick)
         seed_o <= 1'b0;
   end

   assign gen_idx = gen_cnt[GEN_W-1 -: 3];

   ca_rule_table #(
      .NUM_RULES (NUM_RULES)
   ) u_table (
      .clk       (clk),
      .rst_n     (rst_n),
      .wr_en     (accept),
      .wr_addr   (cfg_addr),
      .wr_data   (cfg_data),
      .copy_en   (copy_en),
      .copy_addr (copy_idx),
      .rd_addr   (gen_idx),
      .rd_data   (active_rule)
   );

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         rule_idx_o <= '0;
         rule_o     <= default_rule(0);
      end else begin
         rule_idx_o <= gen_idx;
         rule_o     <= active_rule;
      end
   end

   assign color_o = rule_o[6:1];

endmodule
